pipe_controller: RTL

- Pipelined control unit for the 5-stage ARM-subset core; sits directly upstream of pipe_datapath and drives all its control inputs.
- Decodes InstrD in Decode, carries control bits through D/E, E/M and M/W registers, and evaluates condition codes against a flags register in Execute.
- Exports pipeline-state bits that the hazard unit consumes.

---
 rtl/pipe_ctrl_pkg.sv | 58 +++++
 rtl/pipe_condunit.sv | 57 +++++
 rtl/pipe_controller.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipelined control unit:
// ALU codes, immediate kinds, cond field, op field and stage bundles.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_ORR = 3'b011
  } alu_e;

  typedef enum logic [1:0] {
    IMM8  = 2'b00,
    IMM12 = 2'b01,
    IMM24 = 2'b10
  } imm_e;

  typedef enum logic [3:0] {
    EQ, NE, CS, CC, MI, PL, VS, VC,
    HI, LS, GE, LT, GT, LE, AL, NV
  } cond_e;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  typedef struct packed {
    logic       rw;
    logic       mw;
    logic       mtr;
    logic       br;
    logic       pcs;
    logic [1:0] fw;
    logic [2:0] alu;
    logic       asrc;
    logic [3:0] cond;
  } id_ex_t;

  typedef struct packed {
    logic rw;
    logic mw;
    logic mtr;
    logic pcs;
  } ex_mem_t;

  typedef struct packed {
    logic rw;
    logic mtr;
    logic pcs;
  } mem_wb_t;

endpackage

// File: rtl/pipe_condunit.sv
// NZCV flags register and condition evaluation for Execute.
// Ports: cond_i/flag_we_i from D/E, flags_i from ALU, condex_o result.
module pipe_condunit
  import pipe_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  input  logic [1:0] flag_we_i,
  output logic       condex_o
);

  logic [3:0] flags_q;
  logic [3:0] flags_d;
  logic [1:0] we;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags_q;

  always_comb begin
    condex_o = 1'b0;
    case (cond_i)
      EQ:      condex_o = z;
      NE:      condex_o = ~z;
      CS:      condex_o = c;
      CC:      condex_o = ~c;
      MI:      condex_o = n;
      PL:      condex_o = ~n;
      VS:      condex_o = v;
      VC:      condex_o = ~v;
      HI:      condex_o = c & ~z;
      LS:      condex_o = ~c | z;
      GE:      condex_o = (n == v);
      LT:      condex_o = (n != v);
      GT:      condex_o = ~z & (n == v);
      LE:      condex_o = z | (n != v);
      AL:      condex_o = 1'b1;
      default: condex_o = 1'b0;
    endcase
  end

  // bit1 owns N,Z; bit0 owns C,V
  assign we = flag_we_i & {2{condex_o}};

  always_comb begin
    flags_d = flags_q;
    if (we[1]) flags_d[3:2] = flags_i[3:2];
    if (we[0]) flags_d[1:0] = flags_i[1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= 4'b0000;
    else        flags_q <= flags_d;
  end

endmodule

// File: rtl/pipe_controller.sv
// Pipelined control unit: decodes InstrD and carries control through E/M/W.
// Ports: InstrD/ALUFlagsE/FlushE in; D,E,M,W controls and PCWrPendingF out.
module pipe_controller
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] InstrD,
  input  logic [3:0]  ALUFlagsE,
  input  logic        FlushE,
  output logic [1:0]  RegSrcD,
  output logic [1:0]  ImmSrcD,
  output logic        ALUSrcE,
  output logic [2:0]  ALUControlE,
  output logic        BranchTakenE,
  output logic        MemWriteM,
  output logic        MemtoRegE,
  output logic        RegWriteM,
  output logic        MemtoRegW,
  output logic        PCSrcW,
  output logic        RegWriteW,
  output logic        PCWrPendingF
);

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic [3:0] rd;
  logic       s_bit;
  logic       unused_rn;

  assign op        = InstrD[15:14];
  assign funct     = InstrD[13:8];
  assign cmd       = funct[4:1];
  assign s_bit     = funct[0];
  assign rd        = InstrD[3:0];
  assign unused_rn = ^InstrD[7:4];

  id_ex_t  de_d, de_q;
  ex_mem_t em_d, em_q;
  mem_wb_t mw_d, mw_q;
  logic    condex;

  always_comb begin
    de_d    = '0;
    RegSrcD = 2'b00;
    ImmSrcD = IMM8;
    unique case (1'b1)
      (op == OP_DP): begin
        de_d.asrc = funct[5];
        case (cmd)
          CMD_ADD: begin
            de_d.rw  = 1'b1;
            de_d.alu = ALU_ADD;
            de_d.fw  = {s_bit, s_bit};
          end
          CMD_SUB: begin
            de_d.rw  = 1'b1;
            de_d.alu = ALU_SUB;
            de_d.fw  = {s_bit, s_bit};
          end
          CMD_AND: begin
            de_d.rw  = 1'b1;
            de_d.alu = ALU_AND;
            de_d.fw  = {s_bit, 1'b0};
          end
          CMD_ORR: begin
            de_d.rw  = 1'b1;
            de_d.alu = ALU_ORR;
            de_d.fw  = {s_bit, 1'b0};
          end
          CMD_CMP: begin
            de_d.alu = ALU_SUB;
            de_d.fw  = 2'b11;
          end
          default: ;
        endcase
      end
      (op == OP_MEM): begin
        de_d.asrc = 1'b1;
        de_d.alu  = ALU_ADD;
        ImmSrcD   = IMM12;
        if (funct[0]) begin
          de_d.rw  = 1'b1;
          de_d.mtr = 1'b1;
        end else begin
          de_d.mw    = 1'b1;
          RegSrcD[1] = 1'b1;
        end
      end
      (op == OP_BR): begin
        de_d.br    = 1'b1;
        de_d.asrc  = 1'b1;
        de_d.alu   = ALU_ADD;
        ImmSrcD    = IMM24;
        RegSrcD[0] = 1'b1;
      end
      default: ;
    endcase
    de_d.pcs  = de_d.rw & (rd == 4'hF);
    de_d.cond = InstrD[19:16];
  end

  // flush clears the whole bundle; only write enables matter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      de_q <= '0;
    else if (FlushE) de_q <= '0;
    else             de_q <= de_d;
  end

  pipe_condunit u_cond (
    .clk       (clk),
    .rst_n     (reset),
    .cond_i    (de_q.cond),
    .flags_i   (ALUFlagsE),
    .flag_we_i (de_q.fw),
    .condex_o  (condex)
  );

  assign em_d = '{rw:  de_q.rw & condex,
                  mw:  de_q.mw & condex,
                  mtr: de_q.mtr,
                  pcs: de_q.pcs & condex};

  assign mw_d = '{rw:  em_q.rw,
                  mtr: em_q.mtr,
                  pcs: em_q.pcs};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      em_q <= '0;
      mw_q <= '0;
    end else begin
      em_q <= em_d;
      mw_q <= mw_d;
    end
  end

  assign ALUSrcE      = de_q.asrc;
  assign ALUControlE  = de_q.alu;
  assign MemtoRegE    = de_q.mtr;
  assign BranchTakenE = de_q.br & condex;
  assign MemWriteM    = em_q.mw;
  assign RegWriteM    = em_q.rw;
  assign RegWriteW    = mw_q.rw;
  assign MemtoRegW    = mw_q.mtr;
  assign PCSrcW       = mw_q.pcs;
  assign PCWrPendingF = de_d.pcs | de_q.pcs | em_q.pcs;

endmodule
